// File: rtl/adc_word_align.sv
// Word-alignment stage behind the DDR capture block: trains against a fixed
// pattern by pulsing bitslip, declares lock, then passes aligned words through.
module adc_word_align #(
    parameter logic [15:0] TRAIN_PATTERN = 16'hA55A,
    parameter int          MATCH_COUNT   = 16,
    parameter int          SETTLE_CYCLES = 8,
    parameter int          MAX_SLIPS     = 8,
    parameter int          LOSS_COUNT    = 4,
    localparam int         SLW           = $clog2(MAX_SLIPS + 1)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [15:0]    adc_data,
    input  logic           adc_valid,
    input  logic           train_en,
    output logic           bitslip,
    output logic           aligned,
    output logic           align_err,
    output logic [SLW-1:0] slip_count,
    output logic [15:0]    data_out,
    output logic           data_valid
);
    localparam int SCW = $clog2(SETTLE_CYCLES + 1);
    localparam int MCW = $clog2(MATCH_COUNT + 1);
    localparam int LCW = $clog2(LOSS_COUNT + 1);

    localparam logic [SCW-1:0] SETTLE_LAST = SCW'(SETTLE_CYCLES - 1);
    localparam logic [MCW-1:0] MATCH_LAST  = MCW'(MATCH_COUNT - 1);
    localparam logic [LCW-1:0] LOSS_LAST   = LCW'(LOSS_COUNT - 1);
    localparam logic [SLW-1:0] SLIP_MAX    = SLW'(MAX_SLIPS);

    typedef enum logic [2:0] {IDLE, SETTLE, CHECK, SLIP, LOCKED, FAIL} state_t;

    state_t         state;
    logic [SCW-1:0] settle_cnt;
    logic [MCW-1:0] match_cnt;
    logic [LCW-1:0] loss_cnt;
    logic           match;

    assign match = (adc_data == TRAIN_PATTERN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            settle_cnt <= '0;
            match_cnt  <= '0;
            loss_cnt   <= '0;
            bitslip    <= 1'b0;
            aligned    <= 1'b0;
            align_err  <= 1'b0;
            slip_count <= '0;
            data_out   <= '0;
            data_valid <= 1'b0;
        end else begin
            data_out   <= adc_data;
            data_valid <= adc_valid && (state == LOCKED) && !train_en;
            bitslip    <= 1'b0;
            case (state)
                IDLE: begin
                    settle_cnt <= '0;
                    match_cnt  <= '0;
                    loss_cnt   <= '0;
                    slip_count <= '0;
                    aligned    <= 1'b0;
                    if (train_en) state <= SETTLE;
                end
                SETTLE: begin
                    if (!train_en) begin
                        state <= IDLE;
                    end else if (settle_cnt == SETTLE_LAST) begin
                        settle_cnt <= '0;
                        match_cnt  <= '0;
                        state      <= CHECK;
                    end else begin
                        settle_cnt <= settle_cnt + 1'b1;
                    end
                end
                CHECK: begin
                    // train_en falling outranks any decision on this word
                    if (!train_en) begin
                        state <= IDLE;
                    end else if (adc_valid) begin
                        if (match) begin
                            if (match_cnt == MATCH_LAST) begin
                                aligned  <= 1'b1;
                                loss_cnt <= '0;
                                state    <= LOCKED;
                            end else begin
                                match_cnt <= match_cnt + 1'b1;
                            end
                        end else if (slip_count == SLIP_MAX) begin
                            align_err <= 1'b1;
                            state     <= FAIL;
                        end else begin
                            bitslip    <= 1'b1;
                            slip_count <= slip_count + 1'b1;
                            state      <= SLIP;
                        end
                    end
                end
                SLIP: begin
                    settle_cnt <= '0;
                    state      <= train_en ? SETTLE : IDLE;
                end
                LOCKED: begin
                    if (!train_en) begin
                        loss_cnt <= '0;
                    end else if (adc_valid) begin
                        if (match) begin
                            loss_cnt <= '0;
                        end else if (loss_cnt == LOSS_LAST) begin
                            aligned    <= 1'b0;
                            slip_count <= '0;
                            loss_cnt   <= '0;
                            settle_cnt <= '0;
                            state      <= SETTLE;
                        end else begin
                            loss_cnt <= loss_cnt + 1'b1;
                        end
                    end
                end
                FAIL: begin
                    if (!train_en) begin
                        align_err <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
